rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
Owns the single read/write port of the on-chip game ROM block RAM. During a ROM download it sequences the data_io write stream into that RAM, and it holds the game core in reset while doing so. Outside a download it shares the read port between the CPU and the graphics/video fetcher using round-robin arbitration. It sits between data_io / the galaxian core and the ROM RAM, and runs in the clk_12 domain.

Parameters:
AW, 16, address width of download, requester and memory buses
ROM_SIZE, 16'h6020, number of valid ROM bytes (0x0000–0x601F); writes at or above this address are dropped
RST_HOLD, 16, clk_sys cycles that game_reset stays asserted after a successful download ends

Ports:
clk_sys  in  1  system clock (clk_12)
reset  in  1  synchronous, active-high reset
dl_download  in  1  download active (ioctl_download)
dl_wr  in  1  one-cycle write strobe; at least 2 cycles between strobes
dl_addr  in  AW  download byte address
dl_data  in  8  download byte
cpu_req  in  1  CPU read request (level)
cpu_addr  in  AW  CPU read address; held stable while cpu_req is high
cpu_ack  out  1  one-cycle pulse; cpu_dout is valid in the same cycle
cpu_dout  out  8  CPU read data; registered, holds its value until the next CPU ack
gfx_req  in  1  graphics read request (level)
gfx_addr  in  AW  graphics read address
gfx_ack  out  1  one-cycle pulse; gfx_dout is valid in the same cycle
gfx_dout  out  8  graphics read data; registered, holds until the next graphics ack
mem_addr  out  AW  RAM address (registered)
mem_we  out  1  RAM write enable (registered)
mem_din  out  8  RAM write data (registered)
mem_dout  in  8  RAM read data; synchronous RAM, valid 1 cycle after the address is sampled
game_reset  out  1  reset to the game core
dl_done  out  1  last download was complete
dl_count  out  AW  accepted write count; saturates at all-ones

Behaviour:
- Reset values:
  - state = IDLE
  - mem_addr = 0, mem_we = 0, mem_din = 0
  - cpu_ack = 0, gfx_ack = 0, cpu_dout = 0, gfx_dout = 0
  - dl_count = 0, dl_done = 0, game_reset = 1, last_gnt = CPU
- States: IDLE, ADDR, DATA, DL.
- IDLE:
  - If dl_download = 1, go to DL and clear dl_count and dl_done.
  - Otherwise, if any unmasked request is pending, latch its address into mem_addr, record the grantee, and go to ADDR.
- ADDR always goes to DATA.
- DATA captures mem_dout into the grantee's dout, pulses the grantee's ack, sets last_gnt = grantee, and goes to IDLE.
- Read latency: a request first seen in IDLE in cycle N is acked in cycle N+3. Back-to-back reads complete one every 3 cycles.
- Ack masking: in the ack cycle the acked requester's req is ignored, because the requester drops req on seeing ack. This prevents a double grant.
- Arbitration when both requests are pending in IDLE: grant the requester that is not last_gnt. After reset the graphics fetcher therefore wins the first tie. With a single pending request, grant it immediately.
- Download start:
  - dl_download rising while in ADDR/DATA: the read in flight completes and is acked normally; DL is entered from the following IDLE.
  - game_reset asserts in the same cycle dl_download is seen high.
- DL state:
  - Each dl_wr with dl_addr < ROM_SIZE produces, next cycle: mem_addr = dl_addr, mem_din = dl_data, mem_we = 1 for exactly 1 cycle; dl_count increments (saturating).
  - A dl_wr with dl_addr >= ROM_SIZE is dropped: no write, no count.
  - No reads are granted; cpu_req and gfx_req stay pending and are served after the download.
- Download end (dl_download falls while in DL):
  - If dl_count >= ROM_SIZE: set dl_done = 1, load a hold counter with RST_HOLD, return to IDLE. game_reset deasserts after exactly RST_HOLD cycles.
  - Otherwise dl_done stays 0 and game_reset stays 1 until a later successful download.
- game_reset = reset OR dl_download OR state==DL OR hold counter nonzero OR dl_done==0.
- Reset mid-operation: everything returns to its reset values. An in-flight ack is not delivered, and any write strobe pending in that cycle is lost.
- mem_we is 0 in every state other than the cycle after an accepted dl_wr.

Test Plan:
- Single CPU read, cpu_addr=0x0123, RAM[0x123]=0xA5: cpu_req high at cycle N -> cpu_ack=1 and cpu_dout=0xA5 at N+3; mem_we stays 0; gfx_ack stays 0.
- CPU and graphics request in the same cycle right after reset, addresses 0x10 / 0x4000 -> gfx acked first at N+3, CPU acked at N+6. Both held continuously -> grants alternate G,C,G,C.
- Full download of 0x6020 bytes plus 4 bytes at 0x6020..0x6023 -> exactly 0x6020 single-cycle mem_we pulses with matching addr/data; dl_count=0x6020; dl_done=1; game_reset falls exactly 16 cycles after dl_download falls.
- Truncated download of 0x1000 bytes -> dl_done=0, game_reset stays 1 indefinitely. A following full download -> game_reset releases.
- cpu_req raised during the download -> no cpu_ack while dl_download=1; acked 3 cycles after the first IDLE following the download.
- dl_download rises during a graphics read in ADDR -> gfx_ack still delivered with the correct data; the first mem_we occurs only after that ack. Reset asserted in DATA -> no ack, and all outputs at reset values next cycle.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// Single-port game ROM controller: sequences data_io download writes into the ROM RAM
// and round-robins the read port between the CPU and the graphics fetcher.
module rom_port_arbiter #(
  parameter int          AW       = 16,
  parameter int unsigned ROM_SIZE = 32'h6020,
  parameter int          RST_HOLD = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          dl_download,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_ack,
  output logic [7:0]    cpu_dout,
  input  logic          gfx_req,
  input  logic [AW-1:0] gfx_addr,
  output logic          gfx_ack,
  output logic [7:0]    gfx_dout,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_dout,
  output logic          game_reset,
  output logic          dl_done,
  output logic [AW-1:0] dl_count
);

  localparam logic [AW-1:0] ROM_LIMIT = AW'(ROM_SIZE);
  localparam int            HW        = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DL} state_t;
  typedef enum logic       {GNT_CPU, GNT_GFX}     gnt_t;

  state_t        state, state_next;
  gnt_t          gnt, last_gnt;
  logic [HW-1:0] hold_cnt;

  logic cpu_pend, gfx_pend, pick_gfx;
  logic start_rd, start_dl, end_dl, wr_ok;

  // A requester that is being acked this cycle drops req on seeing the ack,
  // so its still-high req must not be taken as a fresh request.
  assign cpu_pend = cpu_req & ~cpu_ack;
  assign gfx_pend = gfx_req & ~gfx_ack;
  assign pick_gfx = gfx_pend & (~cpu_pend | (last_gnt == GNT_CPU));

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, otherwise a path that
  // does not assign it would infer a latch.
  always_comb begin
    state_next = state;
    start_rd   = 1'b0;
    start_dl   = 1'b0;
    end_dl     = 1'b0;
    wr_ok      = 1'b0;
    case (state)
      IDLE: begin
        if (dl_download) begin
          state_next = DL;
          start_dl   = 1'b1;
        end else if (cpu_pend || gfx_pend) begin
          state_next = ADDR;
          start_rd   = 1'b1;
        end
      end
      ADDR: state_next = DATA;
      DATA: state_next = IDLE;
      DL: begin
        wr_ok = dl_wr && (dl_addr < ROM_LIMIT);
        if (!dl_download) begin
          state_next = IDLE;
          end_dl     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mem_addr <= '0;
      mem_we   <= 1'b0;
      mem_din  <= '0;
      cpu_ack  <= 1'b0;
      gfx_ack  <= 1'b0;
      cpu_dout <= '0;
      gfx_dout <= '0;
      dl_count <= '0;
      dl_done  <= 1'b0;
      hold_cnt <= '0;
      gnt      <= GNT_CPU;
      last_gnt <= GNT_CPU;
    end else begin
      mem_we  <= wr_ok;
      cpu_ack <= 1'b0;
      gfx_ack <= 1'b0;

      if (hold_cnt != '0) hold_cnt <= hold_cnt - HW'(1);

      if (start_rd) begin
        mem_addr <= pick_gfx ? gfx_addr : cpu_addr;
        gnt      <= pick_gfx ? GNT_GFX : GNT_CPU;
      end

      // RAM data for the address presented in ADDR is on mem_dout during DATA.
      if (state == DATA) begin
        if (gnt == GNT_GFX) begin
          gfx_dout <= mem_dout;
          gfx_ack  <= 1'b1;
        end else begin
          cpu_dout <= mem_dout;
          cpu_ack  <= 1'b1;
        end
        last_gnt <= gnt;
      end

      if (start_dl) begin
        dl_count <= '0;
        dl_done  <= 1'b0;
      end

      if (wr_ok) begin
        mem_addr <= dl_addr;
        mem_din  <= dl_data;
        if (dl_count != '1) dl_count <= dl_count + AW'(1);
      end

      if (end_dl && (dl_count >= ROM_LIMIT)) begin
        dl_done  <= 1'b1;
        hold_cnt <= HW'(RST_HOLD);
      end
    end
  end

  // The core stays in reset until a complete image is loaded and has settled.
  assign game_reset = reset | dl_download | (state == DL) | (hold_cnt != '0) | ~dl_done;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a behavioural synchronous ROM RAM and
// a queue of expected download writes.
module tb_rom_port_arbiter;

  localparam int AW = 16;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          dl_download, dl_wr;
  logic [AW-1:0] dl_addr;
  logic [7:0]    dl_data;
  logic          cpu_req, gfx_req;
  logic [AW-1:0] cpu_addr, gfx_addr;
  logic          cpu_ack, gfx_ack;
  logic [7:0]    cpu_dout, gfx_dout;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_din, mem_dout;
  logic          game_reset, dl_done;
  logic [AW-1:0] dl_count;

  rom_port_arbiter dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .dl_download(dl_download),
    .dl_wr      (dl_wr),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_ack    (cpu_ack),
    .cpu_dout   (cpu_dout),
    .gfx_req    (gfx_req),
    .gfx_addr   (gfx_addr),
    .gfx_ack    (gfx_ack),
    .gfx_dout   (gfx_dout),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .game_reset (game_reset),
    .dl_done    (dl_done),
    .dl_count   (dl_count)
  );

  always #5 clk_sys = ~clk_sys;

  // Image byte pattern; chosen so that 0x0123 holds 0xA5, 0x0010 holds 0x97 and
  // 0x4000 holds 0xC7 both before and after a download.
  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h87;
  endfunction

  logic [7:0] ram [0:65535];
  always @(posedge clk_sys) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_wr [$];
  wr_t mon_w;
  int  n_wr = 0;

  always @(negedge clk_sys) begin
    if (mem_we === 1'b1) begin
      n_wr++;
      if (exp_wr.size() == 0) begin
        check("mem_we_unexpected", 32'(mem_we), 32'd0);
      end else begin
        mon_w = exp_wr.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(mon_w.a));
        check("wr_data", 32'(mem_din), 32'(mon_w.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic dl_write(input logic [15:0] a);
    dl_addr = a;
    dl_data = pat(a);
    dl_wr   = 1'b1;
    if (a < 16'h6020) exp_wr.push_back('{a: a, d: pat(a)});
    tick();
    dl_wr = 1'b0;
    tick();
  endtask

  int n0;

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = pat(16'(i));
    reset = 1'b1; dl_download = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    cpu_req = 1'b0; gfx_req = 1'b0; cpu_addr = '0; gfx_addr = '0;
    repeat (3) tick();

    check("rst_mem_addr",   32'(mem_addr),   32'h0);
    check("rst_mem_we",     32'(mem_we),     32'h0);
    check("rst_mem_din",    32'(mem_din),    32'h0);
    check("rst_cpu_ack",    32'(cpu_ack),    32'h0);
    check("rst_gfx_ack",    32'(gfx_ack),    32'h0);
    check("rst_cpu_dout",   32'(cpu_dout),   32'h0);
    check("rst_gfx_dout",   32'(gfx_dout),   32'h0);
    check("rst_dl_count",   32'(dl_count),   32'h0);
    check("rst_dl_done",    32'(dl_done),    32'h0);
    check("rst_game_reset", 32'(game_reset), 32'h1);

    // Tie right after reset: graphics wins first, then grants alternate.
    reset = 1'b0;
    cpu_req = 1'b1; cpu_addr = 16'h0010;
    gfx_req = 1'b1; gfx_addr = 16'h4000;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("tie_cpu_ack_%0d", k), 32'(cpu_ack), 32'(k % 6 == 0));
      check($sformatf("tie_gfx_ack_%0d", k), 32'(gfx_ack), 32'((k % 3 == 0) && (k % 6 != 0)));
      if (k % 6 == 0) check($sformatf("tie_cpu_dout_%0d", k), 32'(cpu_dout), 32'h97);
      else if (k % 3 == 0) check($sformatf("tie_gfx_dout_%0d", k), 32'(gfx_dout), 32'hC7);
    end
    cpu_req = 1'b0; gfx_req = 1'b0;
    repeat (3) tick();

    // Single CPU read.
    cpu_addr = 16'h0123; cpu_req = 1'b1;
    tick(); check("cpu_n1_ack", 32'(cpu_ack), 32'h0);
    tick(); check("cpu_n2_ack", 32'(cpu_ack), 32'h0);
    tick();
    check("cpu_n3_ack",  32'(cpu_ack),  32'h1);
    check("cpu_n3_dout", 32'(cpu_dout), 32'hA5);
    check("cpu_n3_gfx",  32'(gfx_ack),  32'h0);
    cpu_req = 1'b0;
    tick();
    check("cpu_ack_pulse", 32'(cpu_ack),  32'h0);
    check("cpu_dout_hold", 32'(cpu_dout), 32'hA5);
    repeat (2) tick();

    // Download requested while a graphics read sits in ADDR.
    gfx_addr = 16'h4000; gfx_req = 1'b1;
    n0 = n_wr;
    tick();
    dl_download = 1'b1;
    tick(); check("dlrd_gfx_ack_early", 32'(gfx_ack), 32'h0);
    tick();
    check("dlrd_gfx_ack",  32'(gfx_ack),  32'h1);
    check("dlrd_gfx_dout", 32'(gfx_dout), 32'hC7);
    check("dlrd_no_wr_before_ack", 32'(n_wr), 32'(n0));
    gfx_req = 1'b0;
    tick();
    dl_write(16'h0200);
    check("dlrd_count", 32'(dl_count), 32'h1);
    dl_download = 1'b0;
    tick();
    check("dlrd_done", 32'(dl_done), 32'h0);
    repeat (20) tick();
    check("dlrd_game_reset", 32'(game_reset), 32'h1);

    // Truncated download with a CPU request parked during it.
    dl_download = 1'b1;
    tick(); tick();
    cpu_addr = 16'h0123; cpu_req = 1'b1;
    for (int i = 0; i < 16'h1000; i++) begin
      dl_write(16'(i));
      check("trunc_cpu_ack_in_dl", 32'(cpu_ack), 32'h0);
    end
    dl_download = 1'b0;
    check("trunc_count", 32'(dl_count), 32'h1000);
    tick(); check("trunc_cpu_f1", 32'(cpu_ack), 32'h0);
    tick(); check("trunc_cpu_f2", 32'(cpu_ack), 32'h0);
    tick(); check("trunc_cpu_f3", 32'(cpu_ack), 32'h0);
    tick();
    check("trunc_cpu_ack",  32'(cpu_ack),  32'h1);
    check("trunc_cpu_dout", 32'(cpu_dout), 32'hA5);
    cpu_req = 1'b0;
    check("trunc_done", 32'(dl_done), 32'h0);
    for (int i = 0; i < 40; i++) begin
      tick();
      check("trunc_game_reset", 32'(game_reset), 32'h1);
    end

    // Full download plus four out-of-range bytes.
    dl_download = 1'b1;
    tick(); tick();
    n0 = n_wr;
    for (int i = 0; i < 16'h6024; i++) dl_write(16'(i));
    dl_download = 1'b0;
    check("full_count", 32'(dl_count), 32'h6020);
    check("full_writes", 32'(n_wr - n0), 32'h6020);
    check("full_rst_f0", 32'(game_reset), 32'h1);
    tick();
    check("full_done", 32'(dl_done), 32'h1);
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("full_hold_%0d", k), 32'(game_reset), 32'h1);
      tick();
    end
    check("full_release", 32'(game_reset), 32'h0);
    check("wr_queue_empty", 32'(exp_wr.size()), 32'h0);

    // game_reset follows dl_download combinationally; empty download leaves it held.
    tick();
    check("pre_dl_game_reset", 32'(game_reset), 32'h0);
    dl_download = 1'b1;
    #1;
    check("dl_same_cycle_reset", 32'(game_reset), 32'h1);
    tick();
    dl_download = 1'b0;
    tick();
    check("empty_dl_done",   32'(dl_done),    32'h0);
    check("empty_dl_count",  32'(dl_count),   32'h0);
    check("empty_dl_greset", 32'(game_reset), 32'h1);

    // Reset during DATA drops the in-flight ack.
    cpu_addr = 16'h0010; cpu_req = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("rdata_cpu_ack",  32'(cpu_ack),    32'h0);
    check("rdata_cpu_dout", 32'(cpu_dout),   32'h0);
    check("rdata_gfx_dout", 32'(gfx_dout),   32'h0);
    check("rdata_mem_addr", 32'(mem_addr),   32'h0);
    check("rdata_mem_we",   32'(mem_we),     32'h0);
    check("rdata_greset",   32'(game_reset), 32'h1);
    cpu_req = 1'b0;
    reset = 1'b0;
    tick();
    check("rdata_cpu_ack_after", 32'(cpu_ack), 32'h0);
    repeat (4) tick();
    check("wr_queue_final", 32'(exp_wr.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
